lpc_io_cycle_ctrl: RTL and testbench

LPC peripheral-side I/O cycle controller that sequences the CPLD register file.
- Decodes host LPC I/O read/write frames on LFRAME_N/LAD that fall in a 32-byte window.
- Drives a single-cycle Addr/Wr/Rd/DataWrSW access into the register block.
- Returns read data and SYNC/TAR nibbles on LAD.
- Sits between the LPC pins and the register file, in the Lpc hierarchy.

---
 rtl/lpc_pkg.sv | 34 +++
 rtl/lpc_io_cycle_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lpc_io_cycle_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC definitions: controller states, LAD nibble codes and cycle-type helpers.
// Pure declarations; no timing or flow-control content.
package lpc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_CYCTYPE = 4'd1,
      ST_ADDR    = 4'd2,
      ST_WDATA   = 4'd3,
      ST_HTAR    = 4'd4,
      ST_SYNC    = 4'd5,
      ST_RDATA   = 4'd6,
      ST_PTAR    = 4'd7,
      ST_SKIP    = 4'd8
   } lpc_state_e;

   localparam logic [3:0] LAD_START  = 4'h0;
   localparam logic [3:0] LAD_ABORT  = 4'hF;
   localparam logic [3:0] LAD_TAR    = 4'hF;
   localparam logic [3:0] SYNC_READY = 4'h0;
   localparam logic [3:0] SYNC_LWAIT = 4'h6;
   localparam logic [3:0] CYC_IO_RD  = 4'h0;
   localparam logic [3:0] CYC_IO_WR  = 4'h2;

   // Plain I/O cycles have CYCTYPE bits [3:2] clear; bit 1 is the direction.
   function automatic logic isIoCycle(input logic [3:0] cycType);
      return cycType[3:2] == CYC_IO_RD[3:2];
   endfunction

   function automatic logic isWriteCycle(input logic [3:0] cycType);
      return cycType[1] == CYC_IO_WR[1];
   endfunction

endpackage

// File: rtl/lpc_io_cycle_ctrl.sv
// LPC target for I/O cycles into a 2^SPAN_BITS-byte register window; one Wr/Rd strobe per frame.
// All outputs registered; SYNC inserts SYNC_WAITS long-wait cycles, the host cannot stall us.
module lpc_io_cycle_ctrl
   import lpc_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'h0800,
   parameter int unsigned SPAN_BITS  = 5,
   parameter int unsigned SYNC_WAITS = 0
) (
   input  logic       LpcClock,
   input  logic       PciReset,
   input  logic       LFRAME_N,
   input  logic [3:0] LadIn,
   output logic [3:0] LadOut,
   output logic       LadOe,
   output logic [7:0] Addr,
   output logic       Wr,
   output logic       Rd,
   output logic [7:0] DataWrSW,
   input  logic [7:0] DataRd,
   output logic       Busy
);

   localparam logic [15:0] WinMask   = 16'((32'd1 << SPAN_BITS) - 32'd1);
   localparam logic [7:0]  AddrMask  = WinMask[7:0];
   localparam logic [3:0]  SyncWaits = 4'(SYNC_WAITS);

   lpc_state_e state, nextState;
   logic [1:0]  nib, nextNib;
   logic [3:0]  waitCnt, nextWait;
   logic [15:0] ioAddr;
   logic [15:0] addrFull;
   logic        dir;
   logic [7:0]  rdLatch;
   logic        addrHit;
   logic        frameStart;
   logic        frameAbort;

   logic [3:0] ladOutN;
   logic       ladOeN;
   logic       wrN;
   logic       rdN;
   logic       busyN;
   logic [7:0] addrN;
   logic [7:0] dataWrN;

   // Address including the nibble currently on LAD, so the 4th nibble decodes without waiting.
   assign addrFull   = {ioAddr[11:0], LadIn};
   assign addrHit    = (addrFull & ~WinMask) == (BASE_ADDR & ~WinMask);
   assign frameStart = !LFRAME_N && (LadIn == LAD_START);
   assign frameAbort = !LFRAME_N && (LadIn == LAD_ABORT);

   always_ff @(posedge LpcClock or posedge PciReset) begin
      if (PciReset) begin
         state   <= ST_IDLE;
         nib     <= 2'd0;
         waitCnt <= 4'd0;
         ioAddr  <= 16'd0;
         dir     <= 1'b0;
         rdLatch <= 8'd0;
      end else begin
         state   <= nextState;
         nib     <= nextNib;
         waitCnt <= nextWait;
         if (state == ST_ADDR)
            ioAddr <= addrFull;
         if (state == ST_CYCTYPE)
            dir <= isWriteCycle(LadIn);
         // Rd is high in the first HTAR cycle, so DataRd reflects the strobed register here.
         if (state == ST_HTAR && nib == 2'd0 && !dir)
            rdLatch <= DataRd;
      end
   end

   always_comb begin
      nextState = state;
      nextNib   = nib;
      nextWait  = waitCnt;
      if (frameStart) begin
         nextState = ST_CYCTYPE;
         nextNib   = 2'd0;
         nextWait  = 4'd0;
      end else if (frameAbort) begin
         nextState = ST_IDLE;
         nextNib   = 2'd0;
         nextWait  = 4'd0;
      end else if (!LFRAME_N) begin
         // Some other START code: a frame that is not ours.
         nextState = ST_SKIP;
         nextNib   = 2'd0;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_CYCTYPE: begin
               nextNib   = 2'd0;
               nextState = isIoCycle(LadIn) ? ST_ADDR : ST_SKIP;
            end
            ST_ADDR: begin
               if (nib == 2'd3) begin
                  nextNib = 2'd0;
                  if (!addrHit)
                     nextState = ST_SKIP;
                  else
                     nextState = dir ? ST_WDATA : ST_HTAR;
               end else begin
                  nextNib = nib + 2'd1;
               end
            end
            ST_WDATA: begin
               if (nib == 2'd1) begin
                  nextState = ST_HTAR;
                  nextNib   = 2'd0;
               end else begin
                  nextNib = nib + 2'd1;
               end
            end
            ST_HTAR: begin
               if (nib == 2'd1) begin
                  nextState = ST_SYNC;
                  nextNib   = 2'd0;
                  nextWait  = 4'd0;
               end else begin
                  nextNib = nib + 2'd1;
               end
            end
            ST_SYNC: begin
               if (waitCnt == SyncWaits) begin
                  nextState = dir ? ST_PTAR : ST_RDATA;
                  nextNib   = 2'd0;
               end else begin
                  nextWait = waitCnt + 4'd1;
               end
            end
            ST_RDATA: begin
               if (nib == 2'd1) begin
                  nextState = ST_PTAR;
                  nextNib   = 2'd0;
               end else begin
                  nextNib = nib + 2'd1;
               end
            end
            ST_PTAR: begin
               if (nib == 2'd1) begin
                  nextState = ST_IDLE;
                  nextNib   = 2'd0;
               end else begin
                  nextNib = nib + 2'd1;
               end
            end
            ST_SKIP: ;
            default: nextState = ST_IDLE;
         endcase
      end
   end

   // Output values for the cycle about to start; the register below makes every output a flop.
   always_comb begin
      ladOutN = LAD_TAR;
      ladOeN  = 1'b0;
      wrN     = 1'b0;
      rdN     = 1'b0;
      busyN   = !(nextState inside {ST_IDLE, ST_SKIP});
      addrN   = Addr;
      dataWrN = DataWrSW;
      case (nextState)
         ST_SYNC: begin
            ladOeN  = 1'b1;
            ladOutN = (nextWait < SyncWaits) ? SYNC_LWAIT : SYNC_READY;
         end
         ST_RDATA: begin
            ladOeN  = 1'b1;
            ladOutN = (nextNib == 2'd0) ? rdLatch[3:0] : rdLatch[7:4];
         end
         ST_PTAR: ladOeN = (nextNib == 2'd0);
         ST_HTAR: begin
            // Only the entry into HTAR strobes, giving a single pulse per frame.
            if (state != ST_HTAR) begin
               wrN = dir;
               rdN = !dir;
            end
         end
         default: ;
      endcase
      if (state == ST_ADDR && nib == 2'd3 && LFRAME_N && addrHit)
         addrN = addrFull[7:0] & AddrMask;
      if (state == ST_WDATA && LFRAME_N) begin
         if (nib == 2'd0)
            dataWrN[3:0] = LadIn;
         else
            dataWrN[7:4] = LadIn;
      end
   end

   always_ff @(posedge LpcClock or posedge PciReset) begin
      if (PciReset) begin
         LadOut   <= LAD_TAR;
         LadOe    <= 1'b0;
         Wr       <= 1'b0;
         Rd       <= 1'b0;
         Busy     <= 1'b0;
         Addr     <= 8'd0;
         DataWrSW <= 8'd0;
      end else begin
         LadOut   <= ladOutN;
         LadOe    <= ladOeN;
         Wr       <= wrN;
         Rd       <= rdN;
         Busy     <= busyN;
         Addr     <= addrN;
         DataWrSW <= dataWrN;
      end
   end

endmodule

// File: tb/tb_lpc_io_cycle_ctrl.sv
// Directed bench for lpc_io_cycle_ctrl: two instances (SYNC_WAITS 0 and 2) share the LPC host pins.
module tb_lpc_io_cycle_ctrl;

   logic       LpcClock = 1'b0;
   logic       PciReset = 1'b1;
   logic       LFRAME_N = 1'b1;
   logic [3:0] LadIn    = 4'hF;

   logic [3:0] LadOut1, LadOut2;
   logic       LadOe1, LadOe2;
   logic [7:0] Addr1, Addr2;
   logic       Wr1, Wr2, Rd1, Rd2;
   logic [7:0] DataWrSW1, DataWrSW2;
   logic [7:0] DataRd1, DataRd2;
   logic       Busy1, Busy2;

   int checks = 0;
   int errors = 0;
   int wr1Cnt = 0, rd1Cnt = 0, wr2Cnt = 0, rd2Cnt = 0;
   int oe1Seen = 0;

   // Register file stand-in: read data is a fixed function of the address (0x0B -> 0xC3).
   assign DataRd1 = Addr1 + 8'hB8;
   assign DataRd2 = Addr2 + 8'hB8;

   always #5 LpcClock = ~LpcClock;

   lpc_io_cycle_ctrl #(.BASE_ADDR(16'h0800), .SPAN_BITS(5), .SYNC_WAITS(0)) dut1 (
      .LpcClock(LpcClock), .PciReset(PciReset), .LFRAME_N(LFRAME_N), .LadIn(LadIn),
      .LadOut(LadOut1), .LadOe(LadOe1), .Addr(Addr1), .Wr(Wr1), .Rd(Rd1),
      .DataWrSW(DataWrSW1), .DataRd(DataRd1), .Busy(Busy1)
   );

   lpc_io_cycle_ctrl #(.BASE_ADDR(16'h0800), .SPAN_BITS(5), .SYNC_WAITS(2)) dut2 (
      .LpcClock(LpcClock), .PciReset(PciReset), .LFRAME_N(LFRAME_N), .LadIn(LadIn),
      .LadOut(LadOut2), .LadOe(LadOe2), .Addr(Addr2), .Wr(Wr2), .Rd(Rd2),
      .DataWrSW(DataWrSW2), .DataRd(DataRd2), .Busy(Busy2)
   );

   always @(negedge LpcClock) begin
      if (Wr1) wr1Cnt++;
      if (Rd1) rd1Cnt++;
      if (Wr2) wr2Cnt++;
      if (Rd2) rd2Cnt++;
      if (LadOe1) oe1Seen++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one LAD nibble, let the next rising edge consume it, sample 1 ns later.
   task automatic drive(input logic f, input logic [3:0] d);
      LFRAME_N = f;
      LadIn    = d;
      @(posedge LpcClock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 4'hF);
   endtask

   logic       expOe1  [1:8];
   logic [3:0] expLad1 [1:8];
   logic       expOe2  [1:8];
   logic [3:0] expLad2 [1:8];

   initial begin
      expOe1  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      expLad1 = '{4'hF, 4'h0, 4'h3, 4'hC, 4'hF, 4'hF, 4'hF, 4'hF};
      expOe2  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      expLad2 = '{4'hF, 4'h6, 4'h6, 4'h0, 4'h3, 4'hC, 4'hF, 4'hF};

      // Reset state
      #23;
      chk("rst_ladout", 16'(LadOut1), 16'hF);
      chk("rst_ladoe", 16'(LadOe1), 16'h0);
      chk("rst_addr", 16'(Addr1), 16'h0);
      chk("rst_wr_rd", 16'({Wr1, Rd1}), 16'h0);
      chk("rst_datawr", 16'(DataWrSW1), 16'h0);
      chk("rst_busy", 16'(Busy1), 16'h0);
      @(posedge LpcClock);
      #1;
      PciReset = 1'b0;
      idle(2);

      // Write 0x0809 = 0x5A
      wr1Cnt = 0; rd1Cnt = 0;
      drive(1'b0, 4'h0);
      chk("wr_busy_cyctype", 16'(Busy1), 16'h1);
      drive(1'b1, 4'h2);
      drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0); drive(1'b1, 4'h9);
      chk("wr_addr_early", 16'(Addr1), 16'h09);
      chk("wr_no_strobe_yet", 16'(Wr1), 16'h0);
      drive(1'b1, 4'hA); drive(1'b1, 4'h5);
      chk("wr_strobe", 16'(Wr1), 16'h1);
      chk("wr_addr", 16'(Addr1), 16'h09);
      chk("wr_data", 16'(DataWrSW1), 16'h5A);
      chk("wr_htar_oe", 16'(LadOe1), 16'h0);
      drive(1'b1, 4'hF);
      chk("wr_pulse_end", 16'(Wr1), 16'h0);
      drive(1'b1, 4'hF);
      chk("wr_sync_oe", 16'(LadOe1), 16'h1);
      chk("wr_sync_lad", 16'(LadOut1), 16'h0);
      drive(1'b1, 4'hF);
      chk("wr_ptar0_oe", 16'(LadOe1), 16'h1);
      chk("wr_ptar0_lad", 16'(LadOut1), 16'hF);
      drive(1'b1, 4'hF);
      chk("wr_ptar1_oe", 16'(LadOe1), 16'h0);
      drive(1'b1, 4'hF);
      chk("wr_idle_busy", 16'(Busy1), 16'h0);
      idle(4);
      chk("wr_count", 16'(wr1Cnt), 16'd1);
      chk("wr_rd_count", 16'(rd1Cnt), 16'd0);

      // Read 0x080B on both instances; DataRd = 0xC3
      wr1Cnt = 0; rd1Cnt = 0; wr2Cnt = 0; rd2Cnt = 0;
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h0);
      drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0); drive(1'b1, 4'hB);
      chk("rd_strobe1", 16'(Rd1), 16'h1);
      chk("rd_strobe2", 16'(Rd2), 16'h1);
      chk("rd_addr1", 16'(Addr1), 16'h0B);
      chk("rd_htar_oe1", 16'(LadOe1), 16'h0);
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, 4'hF);
         chk($sformatf("rd_oe1_k%0d", k), 16'(LadOe1), 16'(expOe1[k]));
         if (expOe1[k]) chk($sformatf("rd_lad1_k%0d", k), 16'(LadOut1), 16'(expLad1[k]));
         chk($sformatf("rd_oe2_k%0d", k), 16'(LadOe2), 16'(expOe2[k]));
         if (expOe2[k]) chk($sformatf("rd_lad2_k%0d", k), 16'(LadOut2), 16'(expLad2[k]));
      end
      idle(2);
      chk("rd_count1", 16'(rd1Cnt), 16'd1);
      chk("rd_count2", 16'(rd2Cnt), 16'd1);
      chk("rd_wr_count", 16'(wr1Cnt + wr2Cnt), 16'd0);

      // Window miss at 0x0900, then memory cycle type 4'h4
      wr1Cnt = 0; rd1Cnt = 0; oe1Seen = 0;
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h2);
      drive(1'b1, 4'h0); drive(1'b1, 4'h9); drive(1'b1, 4'h0); drive(1'b1, 4'h0);
      chk("miss_busy", 16'(Busy1), 16'h0);
      for (int i = 0; i < 6; i++) drive(1'b1, 4'h5);
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h4);
      chk("mem_busy", 16'(Busy1), 16'h0);
      drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0); drive(1'b1, 4'h9);
      idle(8);
      chk("miss_strobes", 16'(wr1Cnt + rd1Cnt), 16'd0);
      chk("miss_oe", 16'(oe1Seen), 16'd0);
      chk("miss_addr_hold", 16'(Addr1), 16'h0B);

      // Abort after the 2nd address nibble, then a clean write 0x0804 = 0x3C
      wr1Cnt = 0; rd1Cnt = 0;
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h2);
      drive(1'b1, 4'h0); drive(1'b1, 4'h8);
      drive(1'b0, 4'hF);
      chk("abort_busy", 16'(Busy1), 16'h0);
      chk("abort_oe", 16'(LadOe1), 16'h0);
      idle(6);
      chk("abort_no_strobe", 16'(wr1Cnt + rd1Cnt), 16'd0);
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h2);
      drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0); drive(1'b1, 4'h4);
      drive(1'b1, 4'hC); drive(1'b1, 4'h3);
      chk("abw_strobe", 16'(Wr1), 16'h1);
      chk("abw_addr", 16'(Addr1), 16'h04);
      chk("abw_data", 16'(DataWrSW1), 16'h3C);
      idle(8);
      chk("abw_count", 16'(wr1Cnt), 16'd1);

      // Reset pulse while SYNC_WAITS=2 instance drives read data
      rd2Cnt = 0;
      drive(1'b0, 4'h0);
      drive(1'b1, 4'h0);
      drive(1'b1, 4'h0); drive(1'b1, 4'h8); drive(1'b1, 4'h0); drive(1'b1, 4'hB);
      for (int i = 0; i < 5; i++) drive(1'b1, 4'hF);
      chk("rst_pre_oe2", 16'(LadOe2), 16'h1);
      chk("rst_pre_lad2", 16'(LadOut2), 16'h3);
      #2;
      PciReset = 1'b1;
      #1;
      chk("rst_async_oe2", 16'(LadOe2), 16'h0);
      chk("rst_async_busy2", 16'(Busy2), 16'h0);
      chk("rst_async_addr2", 16'(Addr2), 16'h0);
      #3;
      PciReset = 1'b0;
      @(posedge LpcClock);
      #1;
      idle(6);
      chk("rst_post_oe2", 16'(LadOe2), 16'h0);
      chk("rst_rd2_count", 16'(rd2Cnt), 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
